// File: rtl/rr_mux_inv_pipe_pkg.sv
// rr_mux_pkg: shared types and helpers for the rr_mux_inv_pipe selector.
//   mode_e        : arbitration mode (fixed software select / round-robin).
//   rr_grant_t    : result of a round-robin scan (found flag + channel index).
//   next_rr_grant : first valid channel after ptr, wrapping modulo n.
// The scan helper is sized for up to RR_MAX_N channels; callers zero-extend
// their valid vector and pointer into these fixed widths.
package rr_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_grant_t;

  // Scan ptr+1, ptr+2, ... modulo n (not modulo 2^width) and return the
  // first channel whose valid bit is set. ptr itself is checked last.
  function automatic rr_grant_t next_rr_grant(input logic [RR_MAX_N-1:0] valid,
                                              input logic [RR_IDX_W-1:0] ptr,
                                              input int unsigned         n);
    rr_grant_t   g;
    int unsigned cand;
    g.found = 1'b0;
    g.idx   = '0;
    for (int unsigned i = 1; i <= RR_MAX_N; i++) begin
      if (i <= n) begin
        cand = ({27'd0, ptr} + i) % n;
        if (!g.found && valid[cand[RR_IDX_W-1:0]]) begin
          g.found = 1'b1;
          g.idx   = cand[RR_IDX_W-1:0];
        end else begin
          g = g;
        end
      end else begin
        g = g;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_mux_inv_pipe_cond_inv_lane.sv
// cond_inv_lane: W-bit conditional inverter built only from 2:1 muxes.
// Each bit's inverse is a mux choosing constant 0/1; a second mux picks
// between the plain and inverted bit under invert_en_i. Purely combinational.
// Ports:
//   data_i      [W-1:0] word to pass or invert
//   invert_en_i         1 = output ~data_i
//   data_o      [W-1:0] result
module cond_inv_lane #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] data_i,
  input  logic         invert_en_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] inv_s;

  for (genvar b = 0; b < W; b++) begin : g_bit
    // Inverter as a mux with constant data inputs.
    assign inv_s[b]  = data_i[b] ? 1'b0 : 1'b1;
    assign data_o[b] = invert_en_i ? inv_s[b] : data_i[b];
  end

endmodule

// File: rtl/rr_mux_inv_pipe.sv
// rr_mux_inv_pipe: N-channel, W-bit selector with one registered output stage.
// One requesting channel is granted per cycle (fixed select or round-robin),
// optionally inverted, and captured into the output register.
// Optional build macro RR_MUX_INV_PIPE_PARITY_EN adds out_parity (even parity
// of the registered word, computed after inversion).
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   in_valid  [N]      per-channel request
//   in_data   [N*W]    channel k at [k*W +: W]
//   in_ready  [N]      combinational one-hot/zero grant, only while loading
//   mode               0 = fixed (sel_fixed), 1 = round-robin
//   sel_fixed [SELW]   channel used in fixed mode (>= N means no grant)
//   invert_en          invert the selected word before registering
//   out_valid/out_data/out_src  registered output word and its source
//   out_ready          downstream acceptance
//   out_parity         (macro only) XOR of out_data
// N is limited to 2..32 by the shared scan helper.
module rr_mux_inv_pipe
  import rr_mux_pkg::*;
#(
  parameter  int unsigned W    = 8,
  parameter  int unsigned N    = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      in_valid,
  input  logic [N*W-1:0]    in_data,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel_fixed,
  input  logic              invert_en,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_src,
`ifdef RR_MUX_INV_PIPE_PARITY_EN
  output logic              out_parity,
`endif
  input  logic              out_ready
);

  localparam logic [SELW:0]   N_L     = (SELW+1)'(N);
  localparam logic [SELW-1:0] PTR_RST = SELW'(N-1);

`ifdef RR_MUX_INV_PIPE_PARITY_EN
  function automatic logic even_parity(input logic [W-1:0] word);
    return ^word;
  endfunction
`endif

  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        out_data_q,  out_data_d;
  logic [SELW-1:0]     out_src_q,   out_src_d;
  logic [SELW-1:0]     rr_ptr_q,    rr_ptr_d;

  logic                load_s;
  logic [RR_MAX_N-1:0] valid_ext_s;
  logic [RR_IDX_W-1:0] ptr_ext_s;
  logic [RR_IDX_W-1:0] sel_ext_s;
  logic                fixed_ok_s;
  rr_grant_t           rr_grant_s;
  logic                grant_vld_s;
  logic [SELW-1:0]     grant_idx_s;
  logic [W-1:0]        sel_data_s;
  logic [W-1:0]        inv_data_s;
  logic                unused_s;

  // A new word may enter whenever the register is empty or being drained.
  assign load_s     = !out_valid_q || out_ready;
  assign fixed_ok_s = ({1'b0, sel_fixed} < N_L);
  assign rr_grant_s = next_rr_grant(valid_ext_s, ptr_ext_s, N);
  assign unused_s   = ^rr_grant_s.idx;

  // Zero-extend valid vector, pointer and select into the scan helper widths.
  always_comb begin
    valid_ext_s            = '0;
    valid_ext_s[N-1:0]     = in_valid;
    ptr_ext_s              = '0;
    ptr_ext_s[SELW-1:0]    = rr_ptr_q;
    sel_ext_s              = '0;
    sel_ext_s[SELW-1:0]    = sel_fixed;
  end

  // Grant selection for the current mode.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    case (mode_e'(mode))
      MODE_FIXED: begin
        if (fixed_ok_s && valid_ext_s[sel_ext_s]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = sel_fixed;
        end else begin
          grant_vld_s = 1'b0;
        end
      end
      MODE_RR: begin
        grant_vld_s = rr_grant_s.found;
        grant_idx_s = rr_grant_s.idx[SELW-1:0];
      end
      default: begin
        grant_vld_s = 1'b0;
      end
    endcase
  end

  // One-hot ready and AND-OR data mux; ready only while the stage loads.
  always_comb begin
    in_ready   = '0;
    sel_data_s = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = load_s && grant_vld_s && (grant_idx_s == SELW'(k));
      sel_data_s  = sel_data_s | ({W{grant_idx_s == SELW'(k)}} & in_data[k*W +: W]);
    end
  end

  cond_inv_lane #(.W(W)) u_inv (
    .data_i      (sel_data_s),
    .invert_en_i (invert_en),
    .data_o      (inv_data_s)
  );

  // Output stage next state: capture on transfer, empty on load without
  // grant (data/src keep old values), hold everything otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_s) begin
      out_valid_d = grant_vld_s;
      if (grant_vld_s) begin
        out_data_d = inv_data_s;
        out_src_d  = grant_idx_s;
        rr_ptr_d   = grant_idx_s;
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output and pointer registers; reset leaves channel 0 first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= PTR_RST;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef RR_MUX_INV_PIPE_PARITY_EN
  logic parity_q;

  // Parity travels with the data word and is updated only on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (load_s && grant_vld_s) begin
      parity_q <= even_parity(inv_data_s);
    end else begin
      parity_q <= parity_q;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_rr_mux_inv_pipe.sv
// Directed testbench for rr_mux_inv_pipe: a default N=4 instance plus an
// N=3 instance for the out-of-range select and modulo-N wrap cases.
module tb_rr_mux_inv_pipe;

  logic        clk;
  logic        rst_n;

  // N=4, W=8 instance
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel_fixed;
  logic        invert_en;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        out_parity;

  // N=3, W=8 instance
  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel_fixed3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_src3;
  logic        out_parity3;

  int n_checks = 0;
  int n_pass   = 0;

  rr_mux_inv_pipe #(.W(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mode(mode), .sel_fixed(sel_fixed), .invert_en(invert_en),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
`ifdef RR_MUX_INV_PIPE_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready(out_ready)
  );

  rr_mux_inv_pipe #(.W(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .mode(mode3), .sel_fixed(sel_fixed3), .invert_en(1'b0),
    .out_valid(out_valid3), .out_data(out_data3), .out_src(out_src3),
`ifdef RR_MUX_INV_PIPE_PARITY_EN
    .out_parity(out_parity3),
`endif
    .out_ready(1'b1)
  );

`ifndef RR_MUX_INV_PIPE_PARITY_EN
  initial begin
    out_parity  = 1'b0;
    out_parity3 = 1'b0;
  end
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin vectors: channel words and the expected grant order.
  logic [7:0] rr_word [4] = '{8'h11, 8'h23, 8'h33, 8'h47};
  logic       rr_par  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [1:0] rr_src  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [3:0] rr_rdy  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst_n = 1'b0;
    in_valid = 4'b0000; in_data = 32'h0; mode = 1'b0; sel_fixed = 2'd0;
    invert_en = 1'b0; out_ready = 1'b1;
    in_valid3 = 3'b000; in_data3 = 24'h0; mode3 = 1'b0; sel_fixed3 = 2'd0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_src",   {30'd0, out_src},   32'd0);
    chk("rst_out_valid3", {31'd0, out_valid3}, 32'd0);
    rst_n = 1'b1;

    // Fixed select of channel 2, no inversion.
    sel_fixed = 2'd2; in_valid = 4'b0100; in_data = 32'h00A5_0000;
    #1;
    chk("fix_in_ready", {28'd0, in_ready}, 32'h4);
    tick();
    chk("fix_out_valid", {31'd0, out_valid}, 32'd1);
    chk("fix_out_data",  {24'd0, out_data},  32'hA5);
    chk("fix_out_src",   {30'd0, out_src},   32'd2);

    // Same word inverted.
    invert_en = 1'b1;
    #1;
    chk("inv_in_ready", {28'd0, in_ready}, 32'h4);
    tick();
    chk("inv_out_data", {24'd0, out_data}, 32'h5A);
    chk("inv_out_src",  {30'd0, out_src},  32'd2);
`ifdef RR_MUX_INV_PIPE_PARITY_EN
    chk("inv_parity", {31'd0, out_parity}, 32'd0);
`endif

    // Load with nothing requesting: register empties, data/src hold.
    in_valid = 4'b0000; invert_en = 1'b0;
    #1;
    chk("idle_in_ready", {28'd0, in_ready}, 32'h0);
    tick();
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_out_data",  {24'd0, out_data},  32'h5A);
    chk("idle_out_src",   {30'd0, out_src},   32'd2);

    // Fixed select of channel 3 moves the pointer to 3.
    in_data = {rr_word[3], rr_word[2], rr_word[1], rr_word[0]};
    sel_fixed = 2'd3; in_valid = 4'b1000;
    tick();
    chk("fix3_out_src",  {30'd0, out_src},  32'd3);
    chk("fix3_out_data", {24'd0, out_data}, 32'h47);

    // Round-robin, all channels requesting for 8 cycles, no bubbles.
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr%0d_in_ready", i), {28'd0, in_ready}, {28'd0, rr_rdy[i]});
      tick();
      chk($sformatf("rr%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("rr%0d_out_src", i),   {30'd0, out_src},   {30'd0, rr_src[i]});
      chk($sformatf("rr%0d_out_data", i),  {24'd0, out_data},  {24'd0, rr_word[rr_src[i]]});
`ifdef RR_MUX_INV_PIPE_PARITY_EN
      chk($sformatf("rr%0d_parity", i), {31'd0, out_parity}, {31'd0, rr_par[rr_src[i]]});
`endif
    end

    // Backpressure: word from channel 3 held; invert_en change must not touch it.
    out_ready = 1'b0; invert_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", i), {28'd0, in_ready}, 32'h0);
      tick();
      chk($sformatf("bp%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_out_data", i),  {24'd0, out_data},  32'h47);
      chk($sformatf("bp%0d_out_src", i),   {30'd0, out_src},   32'd3);
    end
    out_ready = 1'b1; invert_en = 1'b0;
    #1;
    chk("bp_release_in_ready", {28'd0, in_ready}, 32'h1);
    tick();
    chk("bp_release_out_src",  {30'd0, out_src},  32'd0);
    chk("bp_release_out_data", {24'd0, out_data}, 32'h11);

    // N=3: fixed channel 2, then out-of-range select 3, then RR wrap.
    in_data3 = 24'hC3_0000; in_valid3 = 3'b100; sel_fixed3 = 2'd2;
    tick();
    chk("n3_fix_out_src",  {30'd0, out_src3},  32'd2);
    chk("n3_fix_out_data", {24'd0, out_data3}, 32'hC3);
    sel_fixed3 = 2'd3; in_valid3 = 3'b111;
    #1;
    chk("n3_sel3_in_ready", {29'd0, in_ready3}, 32'h0);
    tick();
    chk("n3_sel3_out_valid", {31'd0, out_valid3}, 32'd0);
    chk("n3_sel3_out_data",  {24'd0, out_data3},  32'hC3);
    mode3 = 1'b1; in_valid3 = 3'b100; in_data3 = 24'h9E_0000;
    #1;
    chk("n3_rr_wrap_in_ready", {29'd0, in_ready3}, 32'h4);
    tick();
    chk("n3_rr_wrap_out_src",  {30'd0, out_src3},  32'd2);
    chk("n3_rr_wrap_out_data", {24'd0, out_data3}, 32'h9E);
    // Pointer now 2; only channel 0 requests -> wraps modulo 3 to channel 0.
    in_valid3 = 3'b001; in_data3 = 24'h00_0077;
    #1;
    chk("n3_rr_wrap0_in_ready", {29'd0, in_ready3}, 32'h1);
    tick();
    chk("n3_rr_wrap0_out_src", {30'd0, out_src3}, 32'd0);

    // Asynchronous reset while a word is held.
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data",  {24'd0, out_data},  32'd0);
    chk("arst_out_src",   {30'd0, out_src},   32'd0);
    rst_n = 1'b1;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_valid3 = 3'b111;
    #1;
    chk("post_rst_in_ready",  {28'd0, in_ready},  32'h1);
    chk("post_rst_in_ready3", {29'd0, in_ready3}, 32'h1);
    tick();
    chk("post_rst_out_src",  {30'd0, out_src},  32'd0);
    chk("post_rst_out_data", {24'd0, out_data}, 32'h11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_inv_pipe.md
Name: rr_mux_inv_pipe

Overview:
- Parametrised N-channel, W-bit selector with a registered output stage and a valid/ready handshake on both sides.
- Picks one requesting input channel per cycle, either a fixed software-selected channel or round-robin across valid channels.
- Optionally inverts the chosen word bitwise; inversion is built from 2:1 muxes with constant inputs.
- Successor to the single-bit mux-based inverter; feeds downstream streaming logic that needs a one-cycle-latency merge point.

Parameters:
- W, 8, data width per channel (>=1).
- N, 4, number of input channels (>=2).
- SELW, $clog2(N), select/source index width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel request; bit k belongs to channel k.
- in_data  input  N*W  packed channel data; channel k occupies [k*W +: W].
- in_ready  output  N  one-hot (or zero) acceptance, combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel_fixed  input  SELW  channel used in fixed mode.
- invert_en  input  1  1 = output bitwise inverse of the selected word.
- out_valid  output  1  registered output word valid.
- out_data  output  W  registered output word.
- out_src  output  SELW  index of the channel that produced out_data.
- out_ready  input  1  downstream acceptance.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, rr_ptr=N-1, so channel 0 has first priority.
- Stage accepts a new word when `load = !out_valid || out_ready` (full-throughput pass-through; no bubble on back-to-back transfers).
- Fixed mode, grant:
  - grant = sel_fixed if in_valid[sel_fixed] && load.
  - If sel_fixed >= N: no grant, in_ready=0.
- Round-robin mode, grant:
  - Grant the first valid channel scanning rr_ptr+1, rr_ptr+2, ... modulo N.
  - Wrap-around is modulo N, not 2^SELW.
- in_ready:
  - in_ready[g]=1 only for the granted channel, and only when load=1.
  - All other bits are 0.
  - in_ready may depend on in_valid; in_valid must not depend on in_ready.
- Transfer on the input side (in_valid[g] && in_ready[g]):
  - Next cycle: out_valid=1, out_data = invert_en ? ~in_data[g] : in_data[g], out_src=g.
  - invert_en is sampled in the same cycle as the data.
- rr_ptr update: rr_ptr <= g on every input transfer, in either mode. Pointer is preserved across mode changes.
- Load with no grant: out_valid <= 0, and out_data/out_src hold their old values.
- Hold (out_valid && !out_ready): out_valid, out_data and out_src stay stable; in_ready=0.
- mode, sel_fixed and invert_en changes take effect in the next arbitration cycle. A word already held in the register is never altered.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Asynchronous reset mid-transfer: the held word is dropped; no partial state survives.

Optional Feature:
- Macro: RR_MUX_INV_PIPE_PARITY_EN.
- Defined:
  - Adds port out_parity (output, 1).
  - out_parity is registered with out_data and equals XOR-reduction of out_data (even parity, computed after inversion).
  - Reset value 0.
  - Held stable together with out_data.
- Undefined: port absent; no parity logic.

Decomposition:
- Package rr_mux_pkg:
  - mode_e enum {MODE_FIXED=1'b0, MODE_RR=1'b1}.
  - Function next_rr_grant(valid, ptr) for the scan, shared with the bench model.
- Sub-module cond_inv_lane:
  - Parameter W.
  - Per-bit 2:1 mux with d0 = data bit, d1 = inverted data bit (itself a mux with constants 1/0), sel = invert_en.
  - Purely combinational; instantiated once before the output register.

Test Plan:
1. Reset, then fixed mode: sel_fixed=2, in_valid=4'b0100, in_data ch2=8'hA5, invert_en=0, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_src=2.
2. Inversion: same as scenario 1 with invert_en=1 -> out_data=8'h5A. With RR_MUX_INV_PIPE_PARITY_EN defined, out_parity=0.
3. Round-robin fairness: mode=1, in_valid=4'b1111 held for 8 cycles, out_ready=1 -> out_src sequence 0,1,2,3,0,1,2,3 with no bubbles.
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_src stable, in_ready=0. Raise out_ready -> next grant transfers in the same cycle.
5. Invalid fixed select and sparse valid:
   - N=3 build, sel_fixed=3 -> in_ready=0 and out_valid drops to 0.
   - mode=1, in_valid=3'b100 with rr_ptr=2 -> grant wraps to channel 2, out_src=2.
6. Reset mid-operation: assert rst_n=0 while out_valid=1 -> out_valid, out_data and out_src become 0 immediately (asynchronously). First post-reset RR grant goes to channel 0.
